// File: rtl/bitplane_sequencer.sv
// Bit-plane (BCM) row/plane sequencer: requests a shifter load for the pending
// row/plane, waits for the display time of the current plane, then latches it.
package params_pkg;
  parameter int BRIGHTNESS_LEVELS = 8;
endpackage

module bitplane_sequencer #(
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int ROWS              = 16
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          shift_start,
  input  logic                          shift_done,
  input  logic                          exceeded_overlap_time,
  output logic [$clog2(ROWS)-1:0]       next_row,
  output logic [BRIGHTNESS_LEVELS-1:0]  next_mask,
  output logic                          row_latch,
  output logic [$clog2(ROWS)-1:0]       row_address,
  output logic [BRIGHTNESS_LEVELS-1:0]  brightness_mask_active,
  output logic                          frame_done
);

  localparam int RW = $clog2(ROWS);
  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_MSB = {1'b1, {(BRIGHTNESS_LEVELS-1){1'b0}}};
  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_LSB = BRIGHTNESS_LEVELS'(1);
  localparam logic [RW-1:0]                LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_REQ,
    SHIFT_WAIT,
    DISPLAY_WAIT,
    LATCH
  } state_e;

  state_e                         state_q, state_d;
  logic [RW-1:0]                  next_row_q, next_row_d;
  logic [BRIGHTNESS_LEVELS-1:0]   next_mask_q, next_mask_d;
  logic [RW-1:0]                  row_address_q, row_address_d;
  logic [BRIGHTNESS_LEVELS-1:0]   mask_active_q, mask_active_d;
  logic                           first_step_q, first_step_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d       = state_q;
    next_row_d    = next_row_q;
    next_mask_d   = next_mask_q;
    row_address_d = row_address_q;
    mask_active_d = mask_active_q;
    first_step_d  = first_step_q;

    unique case (state_q)
      IDLE:       if (enable) state_d = SHIFT_REQ;
      SHIFT_REQ:  state_d = SHIFT_WAIT;
      SHIFT_WAIT: if (shift_done) state_d = DISPLAY_WAIT;
      DISPLAY_WAIT: begin
        // The very first step after reset has no previous plane to wait out.
        if (first_step_q || exceeded_overlap_time) begin
          state_d       = LATCH;
          row_address_d = next_row_q;
          mask_active_d = next_mask_q;
          first_step_d  = 1'b0;
          if (next_mask_q == MASK_LSB) begin
            next_mask_d = MASK_MSB;
            next_row_d  = (next_row_q == LAST_ROW) ? '0 : next_row_q + RW'(1);
          end else begin
            next_mask_d = next_mask_q >> 1;
          end
        end
      end
      LATCH:      state_d = enable ? SHIFT_REQ : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_row_q    <= '0;
      next_mask_q   <= MASK_MSB;
      row_address_q <= '0;
      mask_active_q <= '0;
      first_step_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      next_row_q    <= next_row_d;
      next_mask_q   <= next_mask_d;
      row_address_q <= row_address_d;
      mask_active_q <= mask_active_d;
      first_step_q  <= first_step_d;
    end
  end

  assign shift_start            = (state_q == SHIFT_REQ);
  assign row_latch              = (state_q == LATCH);
  assign frame_done             = row_latch && (row_address_q == LAST_ROW)
                                  && (mask_active_q == MASK_LSB);
  assign next_row               = next_row_q;
  assign next_mask              = next_mask_q;
  assign row_address            = row_address_q;
  assign brightness_mask_active = mask_active_q;

endmodule

// File: tb/tb_bitplane_sequencer.sv
// Scoreboard bench for bitplane_sequencer (4 planes, 4 rows): expected latch
// contents are queued when a step is started and popped at row_latch.
module tb_bitplane_sequencer;

  localparam int BL   = 4;
  localparam int ROWS = 4;

  typedef struct {
    logic [1:0]    row;
    logic [BL-1:0] mask;
    logic          fd;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          shift_start;
  logic          shift_done;
  logic          exceeded_overlap_time;
  logic [1:0]    next_row;
  logic [BL-1:0] next_mask;
  logic          row_latch;
  logic [1:0]    row_address;
  logic [BL-1:0] brightness_mask_active;
  logic          frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int fd_seen = 0;

  exp_t          exp_q[$];
  logic [1:0]    m_row;
  logic [BL-1:0] m_mask;
  bit            m_first;

  bitplane_sequencer #(.BRIGHTNESS_LEVELS(BL), .ROWS(ROWS)) dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .enable                 (enable),
    .shift_start            (shift_start),
    .shift_done             (shift_done),
    .exceeded_overlap_time  (exceeded_overlap_time),
    .next_row               (next_row),
    .next_mask              (next_mask),
    .row_latch              (row_latch),
    .row_address            (row_address),
    .brightness_mask_active (brightness_mask_active),
    .frame_done             (frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Continuous invariants: strobe exclusivity and one-hot pending plane.
  always @(negedge clk_in) begin
    if (reset === 1'b1) begin
      n_cmp++;
      if ((shift_start && row_latch) || (frame_done && !row_latch) || !$onehot(next_mask)) begin
        n_err++;
        $display("FAIL invariant: shift_start=%b row_latch=%b frame_done=%b next_mask=%b",
                 shift_start, row_latch, frame_done, next_mask);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_row   = 2'd0;
    m_mask  = 4'b1000;
    m_first = 1'b1;
    exp_q.delete();
  endfunction

  // One full step. delay: cycles from shift_start to shift_done (>=1);
  // hold: cycles of exceeded_overlap_time=0 in DISPLAY_WAIT (ignored on the first step).
  task automatic run_step(input int delay, input int hold, input bit drop_en);
    exp_t e;
    bit   first;
    int   cyc;
    first  = m_first;
    e.row  = m_row;
    e.mask = m_mask;
    e.fd   = (m_row == 2'd3) && (m_mask == 4'b0001);
    exp_q.push_back(e);
    m_first = 1'b0;
    if (m_mask == 4'b0001) begin
      m_mask = 4'b1000;
      m_row  = m_row + 2'd1;
    end else begin
      m_mask = m_mask >> 1;
    end

    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (shift_start !== 1'b1 && cyc < 50);
    n_cmp++;
    if (shift_start !== 1'b1) begin
      n_err++;
      $display("FAIL shift_start_timeout: got %b want 1", shift_start);
    end
    n_cmp++;
    if (next_row !== e.row || next_mask !== e.mask) begin
      n_err++;
      $display("FAIL pending_step: got row %0d mask %b want row %0d mask %b",
               next_row, next_mask, e.row, e.mask);
    end

    @(negedge clk_in);
    if (drop_en) enable = 1'b0;
    repeat (delay - 1) @(negedge clk_in);
    shift_done = 1'b1;
    @(negedge clk_in);
    shift_done = 1'b0;
    if (!first) begin
      for (int i = 0; i < hold; i++) begin
        n_cmp++;
        if (row_latch !== 1'b0) begin
          n_err++;
          $display("FAIL hold_no_latch: got row_latch %b want 0 (hold cycle %0d)", row_latch, i);
        end
        @(negedge clk_in);
      end
      exceeded_overlap_time = 1'b1;
    end
    @(negedge clk_in);
    exceeded_overlap_time = 1'b0;

    n_cmp++;
    if (row_latch !== 1'b1) begin
      n_err++;
      $display("FAIL latch_timing: got row_latch %b want 1", row_latch);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (row_address !== e.row || brightness_mask_active !== e.mask || frame_done !== e.fd) begin
      n_err++;
      $display("FAIL latched_step: got row %0d mask %b fd %b want row %0d mask %b fd %b",
               row_address, brightness_mask_active, frame_done, e.row, e.mask, e.fd);
    end
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    shift_done = 1'b0;
    exceeded_overlap_time = 1'b0;
    reset = 1'b0;
    model_reset();
    #13;
    n_cmp++;
    if (shift_start !== 0 || row_latch !== 0 || frame_done !== 0 || row_address !== 0 ||
        brightness_mask_active !== 0 || next_row !== 0 || next_mask !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_values: got ss %b rl %b fd %b row %0d mask %b nrow %0d nmask %b",
               shift_start, row_latch, frame_done, row_address, brightness_mask_active,
               next_row, next_mask);
    end
    @(negedge clk_in);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (shift_start !== 0 || row_latch !== 0 || frame_done !== 0 || row_address !== 0 ||
          brightness_mask_active !== 0 || next_row !== 0 || next_mask !== 4'b1000) begin
        n_err++;
        $display("FAIL idle_disabled: cycle %0d ss %b rl %b row %0d mask %b nmask %b",
                 i, shift_start, row_latch, row_address, brightness_mask_active, next_mask);
      end
    end
  endtask

  task automatic test_first_step();
    enable = 1'b1;
    run_step(3, 0, 1'b0);
  endtask

  task automatic test_overlap_hold();
    run_step(1, 10, 1'b0);
  endtask

  task automatic test_full_frame();
    fd_seen = 0;
    for (int s = 0; s < 15; s++) run_step(1, 0, 1'b0);
    n_cmp++;
    if (fd_seen != 1) begin
      n_err++;
      $display("FAIL frame_done_count: got %0d want 1", fd_seen);
    end
  endtask

  task automatic test_enable_drop();
    logic [1:0]    held_row;
    logic [BL-1:0] held_mask;
    run_step(2, 0, 1'b1);
    held_row  = row_address;
    held_mask = brightness_mask_active;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      shift_done = (i == 2);
      n_cmp++;
      if (shift_start !== 0 || next_row !== m_row || next_mask !== m_mask ||
          row_address !== held_row || brightness_mask_active !== held_mask) begin
        n_err++;
        $display("FAIL idle_hold: ss %b nrow %0d nmask %b row %0d mask %b want ss 0 nrow %0d nmask %b row %0d mask %b",
                 shift_start, next_row, next_mask, row_address, brightness_mask_active,
                 m_row, m_mask, held_row, held_mask);
      end
    end
    shift_done = 1'b0;
    enable = 1'b1;
    run_step(2, 3, 1'b0);
  endtask

  task automatic test_reset_midstep();
    int cyc;
    int guard;
    guard = 0;
    while ((m_row != 2'd2 || m_mask != 4'b1000) && guard < 20) begin
      run_step(1, 0, 1'b0);
      guard++;
    end
    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (shift_start !== 1'b1 && cyc < 50);
    n_cmp++;
    if (shift_start !== 1'b1 || next_row !== 2'd2) begin
      n_err++;
      $display("FAIL reach_row2: got ss %b nrow %0d want ss 1 nrow 2", shift_start, next_row);
    end
    @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (shift_start !== 0 || row_latch !== 0 || frame_done !== 0 || row_address !== 0 ||
        brightness_mask_active !== 0 || next_row !== 0 || next_mask !== 4'b1000) begin
      n_err++;
      $display("FAIL async_reset: got ss %b rl %b row %0d mask %b nrow %0d nmask %b",
               shift_start, row_latch, row_address, brightness_mask_active, next_row, next_mask);
    end
    model_reset();
    @(negedge clk_in);
    reset = 1'b1;
    run_step(2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_overlap_hold();
    test_full_frame();
    test_enable_drop();
    test_reset_midstep();
    repeat (2) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
